// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port DataMemory arbiter.
package dmem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_read, mem_write;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection. DMEM_ARB_ROUND_ROBIN_EN selects round-robin
// tie breaking; otherwise port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = PORT0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner = ~last;
`else
      winner = PORT0;
`endif
    end else if (req1) begin
      winner = PORT1;
    end
  end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported DataMemory: IDLE -> ACCESS -> RESP.
// Optional round-robin tie breaking via DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          winner_q, winner_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic pick_valid, pick_winner, last_win, sel_we;

  dmem_arb_pick u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_win),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  always_comb ptr_d = (state_q == IDLE && pick_valid) ? pick_winner : ptr_q;
  // Reset to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PORT1;
    else     ptr_q <= ptr_d;
  end
  assign last_win = ptr_q;
`else
  assign last_win = PORT1;
`endif

  assign sel_we = (pick_winner == PORT1) ? bus.we1 : bus.we0;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = ACCESS;
          winner_d    = pick_winner;
          gnt0_d      = (pick_winner == PORT0);
          gnt1_d      = (pick_winner == PORT1);
          mem_write_d = sel_we;
          mem_read_d  = ~sel_we;
          mem_addr_d  = (pick_winner == PORT1) ? bus.addr1 : bus.addr0;
          mem_din_d   = (pick_winner == PORT1) ? bus.wdata1 : bus.wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack0_d  = (winner_q == PORT0);
        ack1_d  = (winner_q == PORT1);
        // mem_read_q mirrors the latched direction during ACCESS.
        if (mem_read_q) begin
          if (winner_q == PORT0) rdata0_d = bus.mem_dout;
          else                   rdata1_d = bus.mem_dout;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= PORT0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural DataMemory.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMemory: write at the rising edge, combinational read.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_din;
  end
  assign bus.mem_dout = mem[bus.mem_addr[5:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Single access on one port; called at a negedge while the DUT is in IDLE.
  task automatic access(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    logic [31:0] other_rd;
    other_rd = (p == 0) ? bus.rdata1 : bus.rdata0;
    if (p == 0) begin bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; end
    else        begin bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; end
    @(negedge clk);
    chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, (p == 0) ? 32'd1 : 32'd2);
    chk("mem_addr", bus.mem_addr, addr);
    chk("mem_rw", {30'd0, bus.mem_write, bus.mem_read}, we ? 32'd2 : 32'd1);
    if (we) chk("mem_din", bus.mem_din, wdata);
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    chk("ack", {30'd0, bus.ack1, bus.ack0}, (p == 0) ? 32'd1 : 32'd2);
    chk("resp_mem_rw", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
    if (!we) chk("rdata", (p == 0) ? bus.rdata0 : bus.rdata1, exp_rd);
    chk("other_rdata", (p == 0) ? bus.rdata1 : bus.rdata0, other_rd);
    $display("txn port=%0d we=%0d addr=%h wdata=%h rdata0=%h rdata1=%h",
             p, we, addr, wdata, bus.rdata0, bus.rdata1);
    @(negedge clk);
  endtask

  initial begin
    int          ng;
    logic [3:0]  wins;
    logic [3:0]  exp_wins;
    logic        any_pulse;
    logic        any_mem;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_gnt_ack", {28'd0, bus.gnt1, bus.gnt0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_mem_rw", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write then read on port 0
    access(0, 1'b1, 32'h0, 32'h0000ABCD, 32'h0);
    access(0, 1'b0, 32'h0, 32'h0, 32'h0000ABCD);

    // Cross-port readback
    access(1, 1'b1, 32'h4, 32'h00001234, 32'h0);
    access(0, 1'b0, 32'h4, 32'h0, 32'h00001234);

    // Simultaneous requests from reset
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h0; bus.wdata1 = 32'h0000FFFF;
    @(negedge clk);
    chk("tie_first_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
    bus.req0 = 0;
    @(negedge clk);
    chk("tie_first_ack", {30'd0, bus.ack1, bus.ack0}, 32'd1);
    chk("tie_rdata0", bus.rdata0, 32'h0000ABCD);
    $display("txn port=0 we=0 addr=00000000 rdata0=%h (tie)", bus.rdata0);
    @(negedge clk);
    chk("tie_idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    @(negedge clk);
    chk("tie_second_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
    bus.req1 = 0;
    @(negedge clk);
    chk("tie_second_ack", {30'd0, bus.ack1, bus.ack0}, 32'd2);
    $display("txn port=1 we=1 addr=00000000 wdata=0000ffff (tie)");
    @(negedge clk);
    access(0, 1'b0, 32'h0, 32'h0, 32'h0000FFFF);

    // Repeated ties from reset, both reading
    do_reset();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h4;
    ng = 0;
    wins = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) chk("dual_gnt", 32'd1, 32'd0);
      if (bus.gnt0 || bus.gnt1) begin
        if (ng < 4) wins[ng] = bus.gnt1;
        ng++;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_wins = 4'b1010;
`else
    exp_wins = 4'b0000;
`endif
    chk("rep_tie_count", ng, 32'd4);
    chk("rep_tie_order", {28'd0, wins}, {28'd0, exp_wins});
    $display("txn repeated_ties grants=%0d order=%b", ng, wins);
    @(negedge clk);

    // Reset during ACCESS of a port-1 write
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h8; bus.wdata1 = 32'h00005555;
    @(posedge clk);
    #2;
    chk("pre_rst_mem_write", {31'd0, bus.mem_write}, 32'd1);
    bus.req1 = 0;
    rst = 1'b1;
    #1;
    chk("rst_drop_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_drop_gnt1", {31'd0, bus.gnt1}, 32'd0);
    @(negedge clk);
    chk("rst_no_ack1_a", {31'd0, bus.ack1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_no_ack1_b", {31'd0, bus.ack1}, 32'd0);
    $display("txn reset_during_access mem_write=%0d ack1=%0d", bus.mem_write, bus.ack1);
    access(0, 1'b0, 32'h8, 32'h0, 32'h0);

    // Idle: no activity for 20 cycles
    any_pulse = 1'b0;
    any_mem   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1 || bus.ack0 || bus.ack1) any_pulse = 1'b1;
      if (bus.mem_read || bus.mem_write) any_mem = 1'b1;
    end
    chk("idle_pulses", {31'd0, any_pulse}, 32'd0);
    chk("idle_mem_rw", {31'd0, any_mem}, 32'd0);
    $display("txn idle_20_cycles pulses=%0d mem_rw=%0d", any_pulse, any_mem);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported `DataMemory`. It lets the processor load/store path (port 0) and a loader/debug master (port 1) share one `DataMemory` instance. It arbitrates with a registered grant, then drives one memory cycle per access. It returns read data with a one-cycle acknowledge pulse.

## Interface
- `AW`, 32, address width; passed unchanged to memory.
- `DW`, 32, data width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req0` / `req1`  in  1  access request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  byte address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request accepted, memory access in progress.
- `ack0` / `ack1`  out  1  one-cycle pulse: access complete.
- `rdata0` / `rdata1`  out  DW  read data; valid while the matching `ack` is high after a read.
- `mem_addr`  out  AW  to `DataMemory.Address`.
- `mem_din`  out  DW  to `DataMemory.DataIn`.
- `mem_read`  out  1  to `DataMemory.MemRead`.
- `mem_write`  out  1  to `DataMemory.MemWrite`.
- `mem_dout`  in  DW  from `DataMemory.DataOut`; combinational read data.

## Operation
- **FSM states:** `IDLE`, `ACCESS`, `RESP`.
- **IDLE**
  - If any `req` is high at the rising edge, latch the winner index and that port's `we`/`addr`/`wdata`, then go to `ACCESS`.
  - Otherwise stay in `IDLE`.
- **ACCESS** (exactly 1 cycle)
  - `gnt` of the winner is high.
  - `mem_addr` and `mem_din` come from the latched values.
  - `mem_write` = latched `we`; `mem_read` = not latched `we`.
  - `DataMemory` commits a write at the closing edge.
  - For a read, `mem_dout` is captured into the winner's `rdata` register at the closing edge.
  - Next state is `RESP`.
- **RESP** (exactly 1 cycle)
  - `ack` of the winner is high.
  - `mem_read` and `mem_write` are 0.
  - Next state is `IDLE`.
- **Arbitration** (evaluated only in `IDLE`):
  - Only one port requesting: that port wins.
  - Both requesting: winner per Configuration.
  - `req` is ignored in `ACCESS` and `RESP`.
- **Requester rule:**
  - Hold `req`, `we`, `addr`, `wdata` stable until `gnt` is seen.
  - Deassert `req` by the `RESP` cycle unless a further access is intended. A `req` still high in `IDLE` is a new request.
- **rdata registers:**
  - The losing port's `rdata` is unchanged.
  - Write accesses do not modify any `rdata`.
- **Address:** no alignment check; `addr` is passed through unchanged.

## Timing
- **Reset** (asynchronous, immediate on `rst`):
  - State goes to `IDLE`.
  - All `gnt`, `ack`, `mem_read`, `mem_write` = 0.
  - `mem_addr`, `mem_din`, `rdata0`, `rdata1` = 0.
  - RR pointer = 1, so port 0 wins the first tie.
- **Latency:** request sampled at edge E → `gnt` during cycle E+1 → `ack` (and `rdata`) during cycle E+2.
- **Throughput:** one access per 3 cycles. With `req` held continuously, the next sample edge is the end of the `IDLE` cycle following `RESP`.
- **Reset during ACCESS:** `mem_write` drops at once, so the write is not committed. No `ack` is issued. The port must re-request.
- **Memory side:** all `mem_*` outputs are registered or decoded from registered state; there is no combinational path from `req*` to `mem_*`.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN`
  - Defined: round-robin. On a tie, the port not granted last wins. The pointer updates on every grant.
  - Undefined: fixed priority. Port 0 always wins ties, and the pointer register is not instantiated.
  - Single-request behaviour is identical either way.

## Structure
- **Package `dmem_arb_pkg`:**
  - State enum `IDLE`/`ACCESS`/`RESP` (2-bit encoding).
  - Default `AW`/`DW` constants.
  - Port index constants `PORT0 = 0`, `PORT1 = 1`.
- **Sub-module `dmem_arb_pick`:**
  - Combinational.
  - Inputs: `req0`, `req1`, last-winner pointer.
  - Outputs: `valid`, `winner`.
  - Selects the winner; the macro applies inside it.
- Top level holds the FSM, latch registers, `rdata` registers, and memory drive.

## Test plan
- **Write then read, port 0:** write `0x0000ABCD` to address 0 via port 0, then read address 0 → `gnt0` 1 cycle after the sample edge, `ack0` 2 cycles after, `rdata0` = `0x0000ABCD`, `rdata1` unchanged.
- **Cross-port readback:** port 1 writes `0x00001234` to address 4; port 0 reads address 4 → `rdata0` = `0x00001234`; only `ack0` pulses on the read.
- **Simultaneous requests:** both ports request from reset (port 0 reads address 0, port 1 writes `0xFFFF` to address 0) → port 0 granted first and `rdata0` = `0xABCD`; port 1 granted 3 cycles later. A final read of address 0 returns `0xFFFF`.
- **Repeated ties:** both `req` held high for 12 cycles.
  - With `DMEM_ARB_ROUND_ROBIN_EN`: grants alternate 0, 1, 0, 1.
  - Without it: all 4 grants go to port 0.
- **Reset during ACCESS:** `rst` asserted during a port-1 write of `0x5555` to address 8 → `mem_write` = 0 immediately and no `ack1`. After release, a read of address 8 does not return `0x5555`.
- **Idle:** no requests for 20 cycles → `mem_read` = `mem_write` = 0, and no `gnt` or `ack` pulses.
